otbn_imem_arbiter: RTL

Shares OTBN's single-port instruction memory (IMEM) between the instruction prefetcher and the host bus interface. It sits between `otbn_instruction_fetch`, the host IMEM access path and the IMEM macro. While OTBN executes, the prefetcher owns IMEM exclusively and host accesses are rejected with an error response. While idle, the two requesters are arbitrated, optionally with a starvation guard, and each 1-cycle read response is routed back to its issuer.

---
 rtl/otbn_imem_arbiter_pkg.sv | 20 ++
 rtl/otbn_imem_arbiter_if.sv | 58 +++++
 rtl/prim_flop.sv | 17 +
 rtl/otbn_imem_arbiter.sv | 120 ++++++++++++
 4 files changed

// File: rtl/otbn_imem_arbiter_pkg.sv
// Shared types and constants for the OTBN IMEM arbiter.
// Guard-build depth default lives here as DefaultMaxHostWait.
package otbn_imem_arbiter_pkg;

    localparam int unsigned ImemDataWidth      = 39;
    localparam int unsigned DefaultMaxHostWait = 4;

    typedef enum logic [2:0] {
        ArbOwnNone,
        ArbOwnFetch,
        ArbOwnHostRd,
        ArbOwnHostWr,
        ArbOwnHostErr
    } imem_arb_owner_e;

    function automatic int unsigned vbits(input int unsigned value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/otbn_imem_arbiter_if.sv
// Fetch, host and IMEM buses of the arbiter in one bundle.
// slave is the arbiter's view, master the surrounding system's view.
interface otbn_imem_arbiter_if #(
    parameter int unsigned ImemSizeByte = 4096
);
    import otbn_imem_arbiter_pkg::*;

    localparam int unsigned ImemAddrWidth = vbits(ImemSizeByte);
    localparam int unsigned DW = ImemDataWidth;

    logic                     fetch_req;
    logic [ImemAddrWidth-1:0] fetch_addr;
    logic [DW-1:0]            fetch_rdata;
    logic                     fetch_rvalid;

    logic                     host_req;
    logic                     host_we;
    logic [ImemAddrWidth-1:0] host_addr;
    logic [DW-1:0]            host_wdata;
    logic [DW-1:0]            host_wmask;
    logic                     host_gnt;
    logic [DW-1:0]            host_rdata;
    logic                     host_rvalid;
    logic                     host_err;

    logic                     imem_req;
    logic                     imem_we;
    logic [ImemAddrWidth-1:0] imem_addr;
    logic [DW-1:0]            imem_wdata;
    logic [DW-1:0]            imem_wmask;
    logic [DW-1:0]            imem_rdata;
    logic                     imem_rvalid;

    modport slave (
        input  fetch_req, fetch_addr,
        output fetch_rdata, fetch_rvalid,
        input  host_req, host_we, host_addr,
        input  host_wdata, host_wmask,
        output host_gnt, host_rdata,
        output host_rvalid, host_err,
        output imem_req, imem_we, imem_addr,
        output imem_wdata, imem_wmask,
        input  imem_rdata, imem_rvalid
    );

    modport master (
        output fetch_req, fetch_addr,
        input  fetch_rdata, fetch_rvalid,
        output host_req, host_we, host_addr,
        output host_wdata, host_wmask,
        input  host_gnt, host_rdata,
        input  host_rvalid, host_err,
        input  imem_req, imem_we, imem_addr,
        input  imem_wdata, imem_wmask,
        output imem_rdata, imem_rvalid
    );

endinterface

// File: rtl/prim_flop.sv
// Plain resettable flop used for security-relevant state bits.
module prim_flop #(
    parameter int unsigned Width      = 1,
    parameter logic [Width-1:0] ResetValue = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) q_o <= ResetValue;
        else         q_o <= d_i;
    end

endmodule

// File: rtl/otbn_imem_arbiter.sv
// Shares OTBN's single-port IMEM between the prefetcher and the host.
// OTBN_IMEM_ARB_STARVE_GUARD_EN adds a host starvation guard in idle mode.
module otbn_imem_arbiter
    import otbn_imem_arbiter_pkg::*;
#(
    parameter int unsigned ImemSizeByte = 4096
`ifdef OTBN_IMEM_ARB_STARVE_GUARD_EN
    , parameter int unsigned MaxHostWait = DefaultMaxHostWait
`endif
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        busy_execute_i,
    otbn_imem_arbiter_if.slave          bus,
    output logic                        arb_fatal_err_o
);

    localparam int unsigned ImemAddrWidth = vbits(ImemSizeByte);
    localparam int unsigned DW = ImemDataWidth;

    imem_arb_owner_e rsp_owner_q, rsp_owner_d;
    logic host_rej_q, host_rej_d;
    logic fetch_gnt, host_acc, host_rej, host_force, starve;
    logic own_fetch, own_rd, own_wr;
    logic fatal_d;
    logic [ImemAddrWidth-1:0] addr_d;

    assign host_force = ~busy_execute_i & bus.host_req & starve;
    assign fetch_gnt  = bus.fetch_req & ~host_force;
    assign host_acc   = ~busy_execute_i & bus.host_req &
                        (~bus.fetch_req | host_force);
    assign host_rej   = busy_execute_i & bus.host_req;
    assign host_rej_d = host_rej;

    assign bus.host_gnt = host_acc | host_rej;

`ifdef OTBN_IMEM_ARB_STARVE_GUARD_EN
    logic [3:0] wait_cnt_q, wait_cnt_d;

    assign starve = (wait_cnt_q == 4'(MaxHostWait));

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (busy_execute_i || host_acc) begin
            wait_cnt_d = '0;
        end else if (bus.host_req) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) wait_cnt_q <= '0;
        else         wait_cnt_q <= wait_cnt_d;
    end
`else
    assign starve = 1'b0;
`endif

    always_comb begin
        bus.imem_req   = 1'b0;
        bus.imem_we    = 1'b0;
        addr_d         = '0;
        bus.imem_wdata = '0;
        bus.imem_wmask = '0;
        rsp_owner_d    = ArbOwnNone;
        // A rejected host access can coincide with a fetch; the
        // fetch owns the IMEM response, host_rej_q carries the error.
        if (fetch_gnt) begin
            bus.imem_req = 1'b1;
            addr_d       = bus.fetch_addr;
            rsp_owner_d  = ArbOwnFetch;
        end else if (host_acc) begin
            bus.imem_req   = 1'b1;
            bus.imem_we    = bus.host_we;
            addr_d         = bus.host_addr;
            bus.imem_wdata = bus.host_wdata;
            bus.imem_wmask = bus.host_wmask;
            rsp_owner_d    = bus.host_we ? ArbOwnHostWr : ArbOwnHostRd;
        end else if (host_rej) begin
            rsp_owner_d = ArbOwnHostErr;
        end
    end

    assign bus.imem_addr = addr_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_owner_q <= ArbOwnNone;
            host_rej_q  <= 1'b0;
        end else begin
            rsp_owner_q <= rsp_owner_d;
            host_rej_q  <= host_rej_d;
        end
    end

    assign own_fetch = (rsp_owner_q == ArbOwnFetch);
    assign own_rd    = (rsp_owner_q == ArbOwnHostRd);
    assign own_wr    = (rsp_owner_q == ArbOwnHostWr);

    assign bus.fetch_rvalid = own_fetch & bus.imem_rvalid;
    assign bus.fetch_rdata  = own_fetch ? bus.imem_rdata : {DW{1'b0}};
    assign bus.host_rvalid  = (own_rd & bus.imem_rvalid) | own_wr |
                              host_rej_q;
    assign bus.host_err     = host_rej_q;
    assign bus.host_rdata   = own_rd ? bus.imem_rdata : {DW{1'b0}};

    assign fatal_d = arb_fatal_err_o |
                     (bus.imem_rvalid & ~(own_fetch | own_rd));

    prim_flop #(
        .Width      (1),
        .ResetValue (1'b0)
    ) u_fatal_flop (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (fatal_d),
        .q_o    (arb_fatal_err_o)
    );

endmodule
